// File: rtl/load_data_unit.sv
// MEM-stage load path: one outstanding word-aligned read, then byte/half/word extraction and lwl/lwr merge.
// Optional misaligned-load exception is compiled in with `define LOAD_ALIGN_EXC_EN.
module load_data_unit #(
   parameter int MEM_TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_rt,
   input  logic [4:0]  req_dst,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic        mem_rdata_valid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_dst,
   output logic        wb_err,
   output logic        wb_exc,
   output logic        busy
);

   localparam int CW = $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 2);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_addr;
   logic [2:0]    r_type;
   logic [31:0]   r_rt;
   logic [4:0]    r_dst;
   logic [31:0]   r_wbData;
   logic [4:0]    r_wbDst;
   logic          r_wbErr;
   logic          w_misaligned;
   logic          w_timeout;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_extracted;

`ifdef LOAD_ALIGN_EXC_EN
   logic          r_wbExc;
   assign w_misaligned = req_valid &&
                         ((((req_type == 3'd0) || (req_type == 3'd7)) && (req_addr[1:0] != 2'b00)) ||
                          (((req_type == 3'd1) || (req_type == 3'd2)) && req_addr[0]));
   assign wb_exc = r_wbExc;
`else
   assign w_misaligned = 1'b0;
   assign wb_exc = 1'b0;
`endif

   // The last WAIT cycle is the one in which the counter would reach MEM_TIMEOUT-1.
   assign w_timeout = (r_cnt == LAST_WAIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (req_valid) w_nextState = w_misaligned ? RESP : REQ;
         REQ:     w_nextState = WAIT;
         WAIT:    if (mem_rdata_valid || w_timeout) w_nextState = RESP;
         RESP:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Little-endian lane selection; addr[0] is ignored for halfword loads.
   always_comb begin
      w_extracted = mem_rdata;
      case (r_addr[1:0])
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_type)
         3'd1: w_extracted = {{16{w_half[15]}}, w_half};
         3'd2: w_extracted = {16'h0000, w_half};
         3'd3: w_extracted = {{24{w_byte[7]}}, w_byte};
         3'd4: w_extracted = {24'h000000, w_byte};
         3'd5: begin
            case (r_addr[1:0])
               2'd0:    w_extracted = {mem_rdata[7:0],  r_rt[23:0]};
               2'd1:    w_extracted = {mem_rdata[15:0], r_rt[15:0]};
               2'd2:    w_extracted = {mem_rdata[23:0], r_rt[7:0]};
               default: w_extracted = mem_rdata;
            endcase
         end
         3'd6: begin
            case (r_addr[1:0])
               2'd0:    w_extracted = mem_rdata;
               2'd1:    w_extracted = {r_rt[31:24], mem_rdata[31:8]};
               2'd2:    w_extracted = {r_rt[31:16], mem_rdata[31:16]};
               default: w_extracted = {r_rt[31:8],  mem_rdata[31:24]};
            endcase
         end
         default: w_extracted = mem_rdata;
      endcase
   end

   // Result registers only change on the way into RESP, so they hold between responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_addr   <= '0;
         r_type   <= '0;
         r_rt     <= '0;
         r_dst    <= '0;
         r_wbData <= '0;
         r_wbDst  <= '0;
         r_wbErr  <= 1'b0;
`ifdef LOAD_ALIGN_EXC_EN
         r_wbExc  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_addr <= req_addr;
                  r_type <= req_type;
                  r_rt   <= req_rt;
                  r_dst  <= req_dst;
`ifdef LOAD_ALIGN_EXC_EN
                  if (w_misaligned) begin
                     r_wbData <= req_addr;
                     r_wbDst  <= req_dst;
                     r_wbErr  <= 1'b0;
                     r_wbExc  <= 1'b1;
                  end
`endif
               end
            end
            REQ: r_cnt <= '0;
            WAIT: begin
               if (mem_rdata_valid) begin
                  r_wbData <= w_extracted;
                  r_wbDst  <= r_dst;
                  r_wbErr  <= 1'b0;
`ifdef LOAD_ALIGN_EXC_EN
                  r_wbExc  <= 1'b0;
`endif
               end else if (w_timeout) begin
                  r_wbData <= '0;
                  r_wbDst  <= r_dst;
                  r_wbErr  <= 1'b1;
`ifdef LOAD_ALIGN_EXC_EN
                  r_wbExc  <= 1'b0;
`endif
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign mem_rd_en = (r_state == REQ);
   assign mem_addr  = {r_addr[31:2], 2'b00};
   assign wb_valid  = (r_state == RESP);
   assign wb_data   = r_wbData;
   assign wb_dst    = r_wbDst;
   assign wb_err    = r_wbErr;

endmodule

// File: tb/tb_load_data_unit.sv
// Self-checking bench for load_data_unit: directed corner cases plus randomized loads against a byte-level model.
module tb_load_data_unit;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_type;
   logic [31:0] req_rt;
   logic [4:0]  req_dst;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic        mem_rdata_valid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_dst;
   logic        wb_err;
   logic        wb_exc;
   logic        busy;

   int nCompared = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   load_data_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_type(req_type), .req_rt(req_rt), .req_dst(req_dst),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst(wb_dst),
      .wb_err(wb_err), .wb_exc(wb_exc), .busy(busy)
   );

   // Every comparison in the bench goes through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference result built from individual bytes of memory word and old rt.
   function automatic logic [31:0] refLoad(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] rt, input logic [31:0] m);
      logic [7:0] mb[4];
      logic [7:0] rb[4];
      logic [7:0] res[4];
      logic [31:0] r;
      int ai;
      int h;
      ai = int'(a);
      h = 2 * int'(a[1]);
      for (int i = 0; i < 4; i++) begin
         mb[i] = m[8*i +: 8];
         rb[i] = rt[8*i +: 8];
      end
      r = m;
      case (t)
         3'd1: r = {{16{mb[h+1][7]}}, mb[h+1], mb[h]};
         3'd2: r = {16'h0000, mb[h+1], mb[h]};
         3'd3: r = {{24{mb[ai][7]}}, mb[ai]};
         3'd4: r = {24'h000000, mb[ai]};
         3'd5: begin
            for (int j = 0; j < 4; j++) res[3-j] = (j <= ai) ? mb[ai-j] : rb[3-j];
            r = {res[3], res[2], res[1], res[0]};
         end
         3'd6: begin
            for (int j = 0; j < 4; j++) res[j] = (j <= 3 - ai) ? mb[ai+j] : rb[j];
            r = {res[3], res[2], res[1], res[0]};
         end
         default: r = m;
      endcase
      return r;
   endfunction

   function automatic logic expectException(input logic [2:0] t, input logic [31:0] addr);
      logic mis;
      mis = (((t == 3'd0) || (t == 3'd7)) && (addr[1:0] != 2'b00)) ||
            (((t == 3'd1) || (t == 3'd2)) && addr[0]);
`ifdef LOAD_ALIGN_EXC_EN
      return mis;
`else
      return mis & 1'b0;
`endif
   endfunction

   // One complete load: lat = memory latency in cycles after the strobe, 0 = memory never answers.
   task automatic applyStimulus(input logic [2:0] t, input logic [31:0] addr, input logic [31:0] rt,
                                input logic [4:0] dst, input logic [31:0] m, input int lat, input bit junk);
      logic        expExc;
      logic [31:0] expData;
      int          gotAt;
      int          strobes;
      int          expLat;
      expExc = expectException(t, addr);
      expData = (lat == 0) ? 32'h0 : refLoad(t, addr[1:0], rt, m);
      @(negedge clk);
      checkOutput("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_type = t;
      req_addr = addr;
      req_rt = rt;
      req_dst = dst;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr = $urandom;
      req_rt = $urandom;
      req_dst = 5'($urandom);
      if (expExc) begin
         checkOutput("exc_valid", 32'(wb_valid), 32'd1);
         checkOutput("exc_flag", 32'(wb_exc), 32'd1);
         checkOutput("exc_data", wb_data, addr);
         checkOutput("exc_dst", 32'(wb_dst), 32'(dst));
         checkOutput("exc_no_rd", 32'(mem_rd_en), 32'd0);
         @(negedge clk);
         checkOutput("exc_ready_after", 32'(req_ready), 32'd1);
         checkOutput("exc_valid_drop", 32'(wb_valid), 32'd0);
         return;
      end
      checkOutput("rd_strobe", 32'(mem_rd_en), 32'd1);
      checkOutput("rd_addr", mem_addr, {addr[31:2], 2'b00});
      checkOutput("busy", 32'(busy), 32'd1);
      if (junk) begin
         mem_rdata_valid = 1'b1;
         mem_rdata = $urandom;
      end
      gotAt = 0;
      strobes = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         mem_rdata_valid = 1'b0;
         if (mem_rd_en) strobes++;
         if (wb_valid) begin
            gotAt = k;
            break;
         end
         if (k == lat) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = m;
         end
      end
      expLat = (lat == 0) ? TIMEOUT : lat + 1;
      checkOutput("latency", 32'(gotAt), 32'(expLat));
      checkOutput("extra_strobes", 32'(strobes), 32'd0);
      if (gotAt != 0) begin
         checkOutput("wb_data", wb_data, expData);
         checkOutput("wb_err", 32'(wb_err), (lat == 0) ? 32'd1 : 32'd0);
         checkOutput("wb_exc", 32'(wb_exc), 32'd0);
         checkOutput("wb_dst", 32'(wb_dst), 32'(dst));
      end
      @(negedge clk);
      checkOutput("wb_one_cycle", 32'(wb_valid), 32'd0);
      checkOutput("ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      int sawValid;
      reset = 1'b1;
      req_valid = 1'b0;
      req_addr = '0;
      req_type = '0;
      req_rt = '0;
      req_dst = '0;
      mem_rdata_valid = 1'b0;
      mem_rdata = '0;
      #1;
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
      checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("rst_wb_data", wb_data, 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] directed extraction cases");
      applyStimulus(3'd3, 32'h13, 32'h0, 5'd3, 32'h8000_0000, 1, 1'b0);
      applyStimulus(3'd2, 32'h12, 32'h0, 5'd4, 32'h9ABC_1234, 2, 1'b0);
      applyStimulus(3'd1, 32'h10, 32'h0, 5'd5, 32'h9ABC_1234, 3, 1'b1);
      applyStimulus(3'd5, 32'h1,  32'h1122_3344, 5'd6, 32'hAABB_CCDD, 1, 1'b1);
      applyStimulus(3'd6, 32'h2,  32'h1122_3344, 5'd7, 32'hAABB_CCDD, 2, 1'b0);

      $display("[TB] timeout with no memory response");
      applyStimulus(3'd0, 32'h200, 32'h0, 5'd9, 32'h0, 0, 1'b1);

      $display("[TB] misaligned word load");
      applyStimulus(3'd0, 32'h102, 32'h0, 5'd10, 32'hDEAD_BEEF, 1, 1'b0);

      $display("[TB] reset while waiting for memory");
      @(negedge clk);
      req_valid = 1'b1;
      req_type = 3'd0;
      req_addr = 32'h40;
      req_dst = 5'd1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midrst_ready", 32'(req_ready), 32'd1);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("midrst_wb_data", wb_data, 32'd0);
      checkOutput("midrst_wb_err", 32'(wb_err), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      mem_rdata_valid = 1'b1;
      mem_rdata = 32'h1234_5678;
      sawValid = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         mem_rdata_valid = 1'b0;
         if (wb_valid || mem_rd_en) sawValid++;
      end
      checkOutput("late_data_ignored", 32'(sawValid), 32'd0);
      checkOutput("late_ready", 32'(req_ready), 32'd1);

      $display("[TB] randomized loads");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
                       $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
